// File: rtl/dma_bus_sched_pkg.sv
// rtl/dma_bus_sched_pkg.sv - shared constants and state encoding for the DMA bus scheduler
package dma_bus_sched_pkg;

  localparam int WORD_SIZE        = 16;
  localparam int DEF_MAX_GRANT    = 8;
  localparam int DEF_YIELD_CYCLES = 2;
  localparam int DEF_PEND_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_WAIT_BR   = 3'd2,
    ST_GRANT     = 3'd3,
    ST_YIELD     = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_IRQ       = 3'd6
  } sched_state_e;

endpackage

// File: rtl/dma_req_counter.sv
// rtl/dma_req_counter.sv - saturating up/down count of queued device requests with sticky overflow
module dma_req_counter
  import dma_bus_sched_pkg::*;
#(
  parameter int W = DEF_PEND_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] SAT = '1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count == SAT)
        overflow <= 1'b1;
      else
        count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dma_bus_sched.sv
// rtl/dma_bus_sched.sv - DMA start sequencing, CPU/DMA bus arbitration with forced yield, completion irq
module dma_bus_sched
  import dma_bus_sched_pkg::*;
#(
  parameter int MAX_GRANT    = DEF_MAX_GRANT,
  parameter int YIELD_CYCLES = DEF_YIELD_CYCLES,
  parameter int PEND_W       = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dev_irq,
  output logic              dma_cmd,
  input  logic              dma_br,
  output logic              dma_bg,
  input  logic              dma_write,
  input  logic              dma_done,
  input  logic              cpu_bus_req,
  input  logic              cpu_bus_busy,
  output logic              cpu_stall,
  output logic              cpu_irq,
  input  logic              cpu_irq_ack,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int GW = $clog2(MAX_GRANT + 1);
  localparam int YW = $clog2(YIELD_CYCLES + 1);
  localparam logic [GW-1:0] GMAX  = GW'(MAX_GRANT);
  // The WAIT_BR arbitration cycle is the last of the cycles handed back to the CPU.
  localparam logic [YW-1:0] YEXIT = YW'(YIELD_CYCLES - 1);

  sched_state_e  state;
  logic [GW-1:0] gcnt;
  logic [YW-1:0] ycnt;
  logic          start;

  assign start     = (state == ST_IDLE) && (pending != '0);
  assign cpu_stall = dma_bg & cpu_bus_req;

  dma_req_counter #(.W(PEND_W)) u_req_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (dev_irq),
    .dec      (start),
    .count    (pending),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      dma_cmd <= 1'b0;
      dma_bg  <= 1'b0;
      cpu_irq <= 1'b0;
      gcnt    <= '0;
      ycnt    <= '0;
    end else begin
      dma_cmd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_CMD;
            dma_cmd <= 1'b1;
          end
        end
        ST_CMD: state <= ST_WAIT_BR;
        ST_WAIT_BR: begin
          if (dma_br && !cpu_bus_busy) begin
            state  <= ST_GRANT;
            dma_bg <= 1'b1;
            gcnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (!dma_br) begin
            dma_bg <= 1'b0;
            if (dma_done) begin
              state   <= ST_IRQ;
              cpu_irq <= 1'b1;
            end else begin
              state <= ST_WAIT_DONE;
            end
          end else if (gcnt == GMAX && cpu_bus_req && !dma_write) begin
            // only between bursts: a grant never ends with a write on the bus
            state  <= ST_YIELD;
            dma_bg <= 1'b0;
            gcnt   <= '0;
            ycnt   <= YW'(1);
          end else if (gcnt != GMAX) begin
            gcnt <= gcnt + 1'b1;
          end
        end
        ST_YIELD: begin
          if (ycnt >= YEXIT)
            state <= ST_WAIT_BR;
          else
            ycnt <= ycnt + 1'b1;
        end
        ST_WAIT_DONE: begin
          if (dma_done) begin
            state   <= ST_IRQ;
            cpu_irq <= 1'b1;
          end
        end
        ST_IRQ: begin
          if (cpu_irq_ack) begin
            state   <= ST_IDLE;
            cpu_irq <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_bus_sched.sv
// tb/tb_dma_bus_sched.sv - directed/randomized self-checking bench for dma_bus_sched
module tb_dma_bus_sched;

  localparam int MAX_GRANT    = 8;
  localparam int YIELD_CYCLES = 2;
  localparam int PEND_W       = 2;
  localparam int PMAX         = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dev_irq = 1'b0;
  logic dma_br = 1'b0;
  logic dma_write = 1'b0;
  logic dma_done = 1'b0;
  logic cpu_bus_req = 1'b0;
  logic cpu_bus_busy = 1'b0;
  logic cpu_irq_ack = 1'b0;
  logic dma_cmd, dma_bg, cpu_stall, cpu_irq, overflow;
  logic [PEND_W-1:0] pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dma_bus_sched #(
    .MAX_GRANT    (MAX_GRANT),
    .YIELD_CYCLES (YIELD_CYCLES),
    .PEND_W       (PEND_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dev_irq      (dev_irq),
    .dma_cmd      (dma_cmd),
    .dma_br       (dma_br),
    .dma_bg       (dma_bg),
    .dma_write    (dma_write),
    .dma_done     (dma_done),
    .cpu_bus_req  (cpu_bus_req),
    .cpu_bus_busy (cpu_bus_busy),
    .cpu_stall    (cpu_stall),
    .cpu_irq      (cpu_irq),
    .cpu_irq_ack  (cpu_irq_ack),
    .pending      (pending),
    .overflow     (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (dma_cmd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(dma_cmd), 1);
  endtask

  // Entered in the CMD cycle; DMA requests, holds the bus, then finishes with done.
  task automatic finish_xfer(input int hold, input string tag);
    tick();
    dma_br = 1'b1;
    repeat (hold) tick();
    dma_br = 1'b0;
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk({tag, "_irq"}, 32'(cpu_irq), 1);
    chk({tag, "_bg_off"}, 32'(dma_bg), 0);
    cpu_irq_ack = 1'b1;
    tick();
    cpu_irq_ack = 1'b0;
    chk({tag, "_ack"}, 32'(cpu_irq), 0);
  endtask

  initial begin
    int d, h, b, n, hi, lo, yk, k, bgcnt;
    logic w [64];

    tick();
    tick();
    chk("rst_cmd", 32'(dma_cmd), 0);
    chk("rst_bg", 32'(dma_bg), 0);
    chk("rst_irq", 32'(cpu_irq), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    reset_n = 1'b1;

    // single transfer, CPU idle
    d = $urandom_range(1, 4);
    h = $urandom_range(4, 14);
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    chk("s1_pend_inc", 32'(pending), 1);
    chk("s1_cmd_early", 32'(dma_cmd), 0);
    tick();
    chk("s1_cmd", 32'(dma_cmd), 1);
    chk("s1_pend_dec", 32'(pending), 0);
    tick();
    chk("s1_cmd_pulse", 32'(dma_cmd), 0);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("s1_done_ignored", 32'(cpu_irq), 0);
    repeat (d) tick();
    chk("s1_bg_before_br", 32'(dma_bg), 0);
    dma_br = 1'b1;
    bgcnt = 0;
    for (int i = 0; i < h; i++) begin
      tick();
      if (dma_bg === 1'b1) bgcnt++;
      if (i == 0) begin
        cpu_bus_req = 1'b1;
        #1;
        chk("s1_stall", 32'(cpu_stall), 1);
        cpu_bus_req = 1'b0;
        #1;
        chk("s1_stall_off", 32'(cpu_stall), 0);
      end
    end
    dma_br = 1'b0;
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("s1_bg_cycles", bgcnt, h);
    chk("s1_bg_release", 32'(dma_bg), 0);
    chk("s1_irq", 32'(cpu_irq), 1);
    repeat ($urandom_range(1, 3)) tick();
    chk("s1_irq_held", 32'(cpu_irq), 1);
    cpu_irq_ack = 1'b1;
    tick();
    cpu_irq_ack = 1'b0;
    chk("s1_irq_ack", 32'(cpu_irq), 0);
    chk("s1_pend_end", 32'(pending), 0);

    // CPU busy blocks the grant
    b = $urandom_range(3, 7);
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    wait_cmd("s2_cmd");
    tick();
    cpu_bus_busy = 1'b1;
    dma_br = 1'b1;
    bgcnt = 0;
    repeat (b) begin
      tick();
      if (dma_bg === 1'b1) bgcnt++;
    end
    chk("s2_bg_blocked", bgcnt, 0);
    cpu_bus_busy = 1'b0;
    tick();
    chk("s2_bg_after_busy", 32'(dma_bg), 1);
    tick();
    dma_br = 1'b0;
    tick();
    chk("s2_release", 32'(dma_bg), 0);
    chk("s2_wait_done", 32'(cpu_irq), 0);
    repeat (2) tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("s2_irq", 32'(cpu_irq), 1);
    cpu_irq_ack = 1'b1;
    tick();
    cpu_irq_ack = 1'b0;

    // forced yield: 4-word bursts with random gaps, CPU waiting throughout
    k = 0;
    while (k < 64) begin
      for (int j = 0; j < 4 && k < 64; j++) begin w[k] = 1'b1; k++; end
      n = $urandom_range(1, 3);
      for (int j = 0; j < n && k < 64; j++) begin w[k] = 1'b0; k++; end
    end
    yk = -1;
    for (int i = MAX_GRANT; i < 64; i++)
      if (yk < 0 && !w[i]) yk = i;
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    wait_cmd("s3_cmd");
    tick();
    cpu_bus_req = 1'b1;
    dma_br = 1'b1;
    tick();
    chk("s3_grant", 32'(dma_bg), 1);
    hi = 0;
    while (dma_bg === 1'b1 && hi < 40) begin
      dma_write = w[hi];
      tick();
      hi++;
    end
    dma_write = 1'b0;
    chk("s3_grant_len", hi, yk + 1);
    lo = 0;
    while (dma_bg !== 1'b1 && lo < 20) begin
      tick();
      lo++;
    end
    chk("s3_yield_len", lo, YIELD_CYCLES);
    chk("s3_stall", 32'(cpu_stall), 1);
    cpu_bus_req = 1'b0;
    dma_br = 1'b0;
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("s3_irq", 32'(cpu_irq), 1);
    cpu_irq_ack = 1'b1;
    tick();
    cpu_irq_ack = 1'b0;

    // queue saturation while a transfer is in progress
    n = $urandom_range(4, 6);
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    wait_cmd("s4_cmd");
    dev_irq = 1'b1;
    repeat (n) tick();
    dev_irq = 1'b0;
    chk("s4_pend_sat", 32'(pending), (n < PMAX) ? n : PMAX);
    chk("s4_overflow", 32'(overflow), (n > PMAX) ? 1 : 0);
    finish_xfer(3, "s4_x0");
    for (int i = 0; i < PMAX; i++) begin
      wait_cmd("s4_cmd_next");
      finish_xfer($urandom_range(1, 6), "s4_x");
    end
    repeat (4) tick();
    chk("s4_pend_empty", 32'(pending), 0);
    chk("s4_overflow_sticky", 32'(overflow), 1);
    chk("s4_no_cmd", 32'(dma_cmd), 0);

    // dev_irq coincides with the IDLE->CMD decrement
    dev_irq = 1'b1;
    tick();
    chk("s5_pend_one", 32'(pending), 1);
    tick();
    dev_irq = 1'b0;
    chk("s5_cmd", 32'(dma_cmd), 1);
    chk("s5_pend_hold", 32'(pending), 1);
    finish_xfer(2, "s5_x");
    chk("s5_gap_idle", 32'(dma_cmd), 0);
    tick();
    chk("s5_second_cmd", 32'(dma_cmd), 1);
    chk("s5_pend_zero", 32'(pending), 0);
    finish_xfer(2, "s5_y");

    // reset in the middle of a grant
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    wait_cmd("s6_cmd");
    tick();
    dma_br = 1'b1;
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    chk("s6_bg", 32'(dma_bg), 1);
    chk("s6_pend", 32'(pending), 1);
    chk("s6_ovf_pre", 32'(overflow), 1);
    reset_n = 1'b0;
    dma_br = 1'b0;
    tick();
    chk("s6_rst_bg", 32'(dma_bg), 0);
    chk("s6_rst_irq", 32'(cpu_irq), 0);
    chk("s6_rst_pend", 32'(pending), 0);
    chk("s6_rst_ovf", 32'(overflow), 0);
    chk("s6_rst_cmd", 32'(dma_cmd), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("s6_idle_cmd", 32'(dma_cmd), 0);
    chk("s6_idle_bg", 32'(dma_bg), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_bus_sched.md
# dma_bus_sched

Sequences the 16-bit DMA engine and arbitrates the shared memory bus between the CPU and the DMA. The scheduler queues device-ready events, issues the one-cycle DMA start command and answers the DMA's bus request with a grant only when the CPU is between accesses. It forces a yield between bursts if the DMA has held the bus too long while the CPU is waiting, and converts DMA completion into a CPU interrupt held until acknowledged.

## Interface
- MAX_GRANT, 8: cycles of continuous grant after which a yield is allowed.
- YIELD_CYCLES, 2: cycles the bus is returned to the CPU on a forced yield (≥1).
- PEND_W, 2: width of the pending-request counter; saturates at 2^PEND_W−1.
- CLK  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dev_irq  in  1  device data ready; each high cycle is one request.
- dma_cmd  out  1  one-cycle start pulse to DMA cmd.
- dma_br  in  1  DMA bus request (DMA BR).
- dma_bg  out  1  bus grant to DMA (DMA BG), registered.
- dma_write  in  1  DMA WRITE; high while a 4-word burst is on the bus.
- dma_done  in  1  DMA interrupt; transfer complete.
- cpu_bus_req  in  1  CPU wants the memory bus this cycle.
- cpu_bus_busy  in  1  CPU access in flight; must not be cut.
- cpu_stall  out  1  combinational: dma_bg & cpu_bus_req.
- cpu_irq  out  1  DMA-complete interrupt to CPU, level.
- cpu_irq_ack  in  1  CPU acknowledge, single cycle.
- pending  out  PEND_W  queued, not yet started requests.
- overflow  out  1  sticky: dev_irq arrived while pending saturated.

## Operation
- States: IDLE, CMD, WAIT_BR, GRANT, YIELD, WAIT_DONE, IRQ.
- IDLE: pending≠0 → CMD; pending decrements on that edge.
- CMD: dma_cmd=1 for exactly this cycle → WAIT_BR.
- WAIT_BR: dma_br & !cpu_bus_busy → GRANT; dma_bg set on the same edge. Otherwise stay.
- GRANT: grant counter increments each cycle, saturating at MAX_GRANT.
  - !dma_br & dma_done → IRQ.
  - !dma_br → WAIT_DONE.
  - Counter ≥ MAX_GRANT & cpu_bus_req & !dma_write → YIELD; the counter clears.
  - dma_bg is cleared on the edge leaving GRANT.
- YIELD: dma_bg=0 for YIELD_CYCLES cycles → WAIT_BR. The DMA holds BR and pauses.
- WAIT_DONE: dma_done → IRQ.
- IRQ: cpu_irq=1; cpu_irq_ack → IDLE, and cpu_irq clears on that edge.
- dma_done outside GRANT/WAIT_DONE is ignored. cpu_irq_ack outside IRQ is ignored.
- pending:
  - +1 on dev_irq, −1 on IDLE→CMD; simultaneous → unchanged.
  - dev_irq while saturated and no decrement → overflow=1 until reset.
- Reset values: dma_cmd, dma_bg, cpu_irq, overflow = 0; pending = 0; state IDLE; counters 0.
- Reset mid-grant drops dma_bg on that edge. The DMA is reset by the same reset_n.

## Timing
- dev_irq at edge n, scheduler in IDLE: pending=1 after n, dma_cmd high in cycle n+1 to n+2.
- First dma_bg: one edge after dma_br sampled high with cpu_bus_busy low.
- Release: dma_bg low one edge after dma_br sampled low.
- Yield is only taken between bursts (dma_write low). A grant never ends inside a burst except by reset.
- cpu_irq rises one edge after dma_done is sampled in GRANT/WAIT_DONE.
- Back-to-back requests: IRQ→IDLE→CMD, so at least 2 cycles separate ack and next dma_cmd.

## Structure
- Shared package holds:
  - WORD_SIZE=16
  - state enum encoding
  - default MAX_GRANT/YIELD_CYCLES
- One natural sub-module: dma_req_counter (saturating up/down counter with sticky overflow).
- The FSM and grant/yield counters stay in dma_bus_sched.

## Test plan
- Single transfer, CPU idle:
  - Stimulus: dev_irq pulse; DMA raises br 3 cycles after cmd and holds 12 cycles; done with br fall.
  - Expected: one dma_cmd pulse, dma_bg for 12 cycles, cpu_irq until ack, pending back to 0.
- CPU busy blocks grant: cpu_bus_busy high 5 cycles while dma_br high → dma_bg stays 0, rises one edge after busy falls.
- Forced yield, MAX_GRANT=8 and YIELD_CYCLES=2:
  - Stimulus: cpu_bus_req held; dma_write high cycles 0–3 and 6–9 of the grant.
  - Expected: no yield inside a burst; bg drops at the first gap after count 8, 2 cycles low, then regranted.
- Queue saturation: 4 dev_irq pulses while busy → pending=3, overflow=1; after three transfers, pending=0 and overflow stays 1.
- Simultaneous events: dev_irq in the IDLE→CMD cycle with pending=1 → pending stays 1, second dma_cmd follows the next ack.
- Reset mid-grant: reset_n low during GRANT → next edge dma_bg=0, cpu_irq=0, pending=0, state IDLE.
